// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default sizing for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-macro signals of the arbiter.
interface unified_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [3:0]        ls_wstrb;
    logic              ls_ready;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output ls_ready, ls_rvalid, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    // Requesters plus memory macro view
    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  ls_ready, ls_rvalid, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/unified_mem_arbiter_select.sv
// LS-first winner selection with a saturating starvation counter that forces an IF grant.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic ls_req,
    input  logic grant,
    output logic grant_if,
    output logic grant_ls
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (grant) begin
            if (if_req && (!ls_req || starved)) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
        end
    end

    // Only arbitration cycles move the counter; a waiting IF is what makes LS grants count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (grant_if || !if_req) begin
                starve_cnt <= '0;
            end else if (grant_ls && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter: IF and LS requesters share one fixed-latency memory macro.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus,
    output logic                  busy
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t            state, state_nx;
    owner_t            owner;
    logic [LAT_W-1:0]  lat_cnt;
    logic              arb_en, grant_if, grant_ls, accept, last_wait;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

    // Gating with reset keeps ready low while reset is held, even with requests pending.
    assign arb_en    = reset && ((state == ST_IDLE) || (state == ST_RESP));
    assign accept    = grant_if || grant_ls;
    assign last_wait = (state == ST_WAIT) && (lat_cnt == '0);
    assign busy      = (state != ST_IDLE);

    mem_arb_select #(.STARVE_MAX(STARVE_MAX)) u_select (
        .clk      (clk),
        .reset    (reset),
        .if_req   (bus.if_req),
        .ls_req   (bus.ls_req),
        .grant    (arb_en),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        bus.if_ready  = grant_if;
        bus.ls_ready  = grant_ls;
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = req_we;
                bus.mem_addr  = req_addr;
                bus.mem_wdata = req_wdata;
                bus.mem_wstrb = req_wstrb;
                state_nx      = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == '0) state_nx = ST_RESP;
            end
            ST_RESP: begin
                bus.if_rvalid = (owner == OWN_IF);
                bus.ls_rvalid = (owner == OWN_LS);
                state_nx      = accept ? ST_ISSUE : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (accept) owner <= grant_ls ? OWN_LS : OWN_IF;
            if (state == ST_ISSUE) begin
                lat_cnt <= LAT_W'(MEM_LAT - 1);
            end else if ((state == ST_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            // Data lands on the edge entering RESP, so rdata only changes with its rvalid pulse.
            if (last_wait) begin
                if (owner == OWN_IF) begin
                    if_rdata_q <= bus.mem_rdata;
                end else begin
                    ls_rdata_q <= req_we ? '0 : bus.mem_rdata;
                end
            end
        end
    end

    // Request payload needs no reset: it only reaches the memory through the ISSUE state.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we    <= grant_ls && bus.ls_we;
            req_addr  <= grant_ls ? bus.ls_addr  : bus.if_addr;
            req_wdata <= grant_ls ? bus.ls_wdata : '0;
            req_wstrb <= grant_ls ? bus.ls_wstrb : '0;
        end
    end

    assign bus.if_rdata = if_rdata_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter with a transaction-timing reference model and behavioural memory.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int RESP_OFS   = MEM_LAT + 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    unified_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int idx);
        case (idx)
            0:       return 32'h0020_81B3;
            1:       return 32'h0011_01B3;
            4:       return 32'h0000_00AA;
            5:       return 32'h0000_00BB;
            default: return 32'hC0DE_0000 | 32'(idx);
        endcase
    endfunction

    // Behavioural memory: request seen in the mem_en cycle, read data appears MEM_LAT cycles later.
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [MEM_LAT];

    initial begin : memory_model
        int          midx;
        logic [31:0] rd;
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            rd = '0;
            if (bus.mem_en === 1'b1) begin
                midx = int'(bus.mem_addr[9:2]);
                if (bus.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_wstrb[b]) mem[midx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                end else begin
                    rd = mem[midx];
                end
            end
            @(posedge clk);
            #1;
            for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
            rd_pipe[0] = rd;
            bus.mem_rdata = rd_pipe[MEM_LAT-1];
        end
    end

    // Reference model state and observed-event records
    int          cyc = 0;
    bit          if_hs, ls_hs;
    owner_t      glog [$];
    int          if_acc_cyc = -1, ls_acc_cyc = -1, en_cyc = -1;
    logic [31:0] en_addr;
    int          if_rv_cyc_q [$], ls_rv_cyc_q [$];
    logic [31:0] if_rv_dat_q [$], ls_rv_dat_q [$];
    int          busy_low_cnt = 0;
    logic [31:0] ref_mem [256];

    initial begin : monitor
        bit          outst, en_exp, rv_exp, busy_exp, arb, if_pend, ls_pend;
        int          win, idx, acc, starve;
        owner_t      m_owner;
        logic        m_we;
        logic [31:0] m_addr, m_wdata, m_data, exp_if_rd, exp_ls_rd;
        logic [3:0]  m_wstrb;
        outst = 0; starve = 0; acc = 0; if_pend = 0; ls_pend = 0;
        m_owner = OWN_IF; m_we = 0; m_addr = 0; m_wdata = 0; m_data = 0; m_wstrb = 0;
        exp_if_rd = 0; exp_ls_rd = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                check_eq("rst_ctrl", {bus.if_ready, bus.ls_ready, bus.if_rvalid, bus.ls_rvalid,
                                      bus.mem_en, bus.mem_we, busy}, 7'd0);
                check_eq("rst_data", |{bus.if_rdata, bus.ls_rdata, bus.mem_addr, bus.mem_wdata,
                                       bus.mem_wstrb}, 1'b0);
                outst = 0; starve = 0; exp_if_rd = 0; exp_ls_rd = 0;
                if_hs = 0; ls_hs = 0; if_pend = 0; ls_pend = 0;
            end else begin
                if (if_pend) check_eq("if_req_hold", bus.if_req, 1'b1);
                if (ls_pend) check_eq("ls_req_hold", bus.ls_req, 1'b1);
                en_exp   = outst && (cyc == acc + 1);
                rv_exp   = outst && (cyc == acc + RESP_OFS);
                busy_exp = outst && (cyc > acc);
                arb      = !outst || rv_exp;
                win = 0;
                if (arb) begin
                    if (bus.if_req && bus.ls_req) win = (starve == STARVE_MAX) ? 1 : 2;
                    else if (bus.if_req)          win = 1;
                    else if (bus.ls_req)          win = 2;
                end
                check_eq("if_ready", bus.if_ready, win == 1);
                check_eq("ls_ready", bus.ls_ready, win == 2);
                check_eq("busy", busy, busy_exp);
                check_eq("mem_en", bus.mem_en, en_exp);
                if (en_exp) begin
                    check_eq("mem_we", bus.mem_we, m_we);
                    check_eq("mem_addr", bus.mem_addr, m_addr);
                    if (m_we) begin
                        check_eq("mem_wdata", bus.mem_wdata, m_wdata);
                        check_eq("mem_wstrb", bus.mem_wstrb, m_wstrb);
                    end
                end else begin
                    check_eq("mem_idle", |{bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 1'b0);
                end
                if (rv_exp && m_owner == OWN_IF) exp_if_rd = m_data;
                if (rv_exp && m_owner == OWN_LS) exp_ls_rd = m_data;
                check_eq("if_rvalid", bus.if_rvalid, rv_exp && (m_owner == OWN_IF));
                check_eq("ls_rvalid", bus.ls_rvalid, rv_exp && (m_owner == OWN_LS));
                check_eq("if_rdata", bus.if_rdata, exp_if_rd);
                check_eq("ls_rdata", bus.ls_rdata, exp_ls_rd);
                if (rv_exp) outst = 0;
                if (arb) begin
                    if (win == 1 || !bus.if_req)             starve = 0;
                    else if (win == 2 && starve < STARVE_MAX) starve++;
                end
                if (win != 0) begin
                    outst = 1;
                    acc   = cyc;
                    glog.push_back(win == 1 ? OWN_IF : OWN_LS);
                    if (win == 1) begin
                        m_owner = OWN_IF; m_we = 0; m_addr = bus.if_addr; m_wdata = 0; m_wstrb = 0;
                        m_data  = ref_mem[int'(bus.if_addr[9:2])];
                    end else begin
                        m_owner = OWN_LS; m_we = bus.ls_we; m_addr = bus.ls_addr;
                        m_wdata = bus.ls_wdata; m_wstrb = bus.ls_wstrb;
                        idx = int'(bus.ls_addr[9:2]);
                        if (bus.ls_we) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.ls_wstrb[b]) ref_mem[idx][8*b +: 8] = bus.ls_wdata[8*b +: 8];
                            m_data = 0;
                        end else begin
                            m_data = ref_mem[idx];
                        end
                    end
                end
                if (bus.if_ready) if_acc_cyc = cyc;
                if (bus.ls_ready) ls_acc_cyc = cyc;
                if (bus.mem_en) begin en_cyc = cyc; en_addr = bus.mem_addr; end
                if (bus.if_rvalid) begin if_rv_cyc_q.push_back(cyc); if_rv_dat_q.push_back(bus.if_rdata); end
                if (bus.ls_rvalid) begin ls_rv_cyc_q.push_back(cyc); ls_rv_dat_q.push_back(bus.ls_rdata); end
                if (!busy) busy_low_cnt++;
                if_hs   = bus.if_ready;
                ls_hs   = bus.ls_ready;
                if_pend = bus.if_req && !bus.if_ready;
                ls_pend = bus.ls_req && !bus.ls_ready;
            end
        end
    end

    // Mode per requester: 0 = drop after handshake, 1 = random traffic, 2 = always re-request.
    task automatic cycle_drive(input int mif, input int mls);
        @(posedge clk);
        #1;
        if (if_hs || !bus.if_req) begin
            case (mif)
                1: begin
                    bus.if_req  = ($urandom_range(0, 2) != 0);
                    bus.if_addr = 32'($urandom_range(0, 63)) << 2;
                end
                2:       bus.if_req = 1'b1;
                default: bus.if_req = 1'b0;
            endcase
        end
        if (ls_hs || !bus.ls_req) begin
            case (mls)
                1: begin
                    bus.ls_req   = ($urandom_range(0, 2) != 0);
                    bus.ls_we    = $urandom_range(0, 1) != 0;
                    bus.ls_addr  = 32'($urandom_range(0, 63)) << 2;
                    bus.ls_wdata = $urandom;
                    bus.ls_wstrb = 4'($urandom_range(0, 15));
                end
                2:       bus.ls_req = 1'b1;
                default: bus.ls_req = 1'b0;
            endcase
        end
    endtask

    task automatic settle(input int max, output bit done);
        done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            cycle_drive(0, 0);
            done = !bus.if_req && !bus.ls_req && !busy;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int     t0, n0, m0, g0, b0, gsz;
        bit     done;
        owner_t exp_seq [6];
        exp_seq = '{OWN_LS, OWN_LS, OWN_LS, OWN_LS, OWN_IF, OWN_LS};

        // Reset held with both requests pending
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h0;
        bus.ls_wdata = '0; bus.ls_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ready", {bus.if_ready, bus.ls_ready}, 2'b00);
        t0 = cyc;
        reset = 1'b1;
        settle(40, done);
        check_eq("t1_settle", done, 1'b1);
        check_eq("t1_first_ls_accept", ls_acc_cyc, t0 + 1);
        check_eq("t1_if_accept_in_resp", if_acc_cyc, t0 + 1 + RESP_OFS);

        // IF read only
        m0 = if_rv_cyc_q.size();
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        t0 = cyc;
        settle(30, done);
        check_eq("t2_settle", done, 1'b1);
        check_eq("t2_accept", if_acc_cyc, t0 + 1);
        check_eq("t2_mem_en_cyc", en_cyc, if_acc_cyc + 1);
        check_eq("t2_mem_addr", en_addr, 32'h0);
        check_eq("t2_rv_count", if_rv_cyc_q.size() - m0, 1);
        if (if_rv_cyc_q.size() > m0) begin
            check_eq("t2_rv_cyc", if_rv_cyc_q[m0], if_acc_cyc + RESP_OFS);
            check_eq("t2_rdata", if_rv_dat_q[m0], 32'h0020_81B3);
        end

        // Simultaneous IF read and LS write
        m0 = if_rv_cyc_q.size(); n0 = ls_rv_cyc_q.size();
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h8;
        bus.ls_wdata = 32'd5; bus.ls_wstrb = 4'hF;
        t0 = cyc;
        settle(40, done);
        check_eq("t3_settle", done, 1'b1);
        check_eq("t3_ls_first", ls_acc_cyc, t0 + 1);
        check_eq("t3_ls_rv_count", ls_rv_cyc_q.size() - n0, 1);
        if (ls_rv_cyc_q.size() > n0) begin
            check_eq("t3_ls_rv_cyc", ls_rv_cyc_q[n0], t0 + 1 + RESP_OFS);
            check_eq("t3_ls_rdata", ls_rv_dat_q[n0], 32'h0);
            check_eq("t3_if_in_resp", if_acc_cyc, ls_rv_cyc_q[n0]);
        end
        check_eq("t3_mem2", mem[2], 32'd5);
        if (if_rv_cyc_q.size() > m0) check_eq("t3_if_rdata", if_rv_dat_q[m0], 32'h0011_01B3);

        // Starvation: both held high continuously
        bus.ls_we = 1'b0; bus.ls_addr = 32'h4; bus.if_addr = 32'h0;
        bus.if_req = 1'b1; bus.ls_req = 1'b1;
        g0 = glog.size();
        for (int i = 0; i < 80 && glog.size() < g0 + 6; i++) cycle_drive(2, 2);
        settle(40, done);
        check_eq("t4_settle", done, 1'b1);
        gsz = glog.size();
        for (int k = 0; k < 6; k++)
            check_eq($sformatf("t4_grant%0d", k), (g0 + k < gsz) ? 64'(glog[g0 + k]) : 64'd9, 64'(exp_seq[k]));

        // Reset asserted in the WAIT state of an LS read
        n0 = ls_rv_cyc_q.size();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h10;
        cycle_drive(0, 0);
        cycle_drive(0, 0);
        check_eq("t5_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("t5_async_busy", busy, 1'b0);
        check_eq("t5_async_outs", {bus.mem_en, bus.ls_rvalid, bus.ls_ready}, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m0 = if_rv_cyc_q.size();
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        settle(40, done);
        check_eq("t5_settle", done, 1'b1);
        check_eq("t5_no_ls_rvalid", ls_rv_cyc_q.size(), n0);
        check_eq("t5_if_rv_count", if_rv_cyc_q.size() - m0, 1);
        if (if_rv_cyc_q.size() > m0) check_eq("t5_if_rdata", if_rv_dat_q[m0], 32'h0011_01B3);

        // Back-to-back LS reads
        n0 = ls_rv_cyc_q.size();
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h10;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk);
            #1;
            done = ls_hs;
        end
        check_eq("t6_first_hs", done, 1'b1);
        t0 = ls_acc_cyc;
        b0 = busy_low_cnt;
        bus.ls_addr = 32'h14;
        settle(40, done);
        check_eq("t6_settle", done, 1'b1);
        check_eq("t6_busy_held", busy_low_cnt, b0);
        check_eq("t6_rv_count", ls_rv_cyc_q.size() - n0, 2);
        if (ls_rv_cyc_q.size() >= n0 + 2) begin
            check_eq("t6_rv0_cyc", ls_rv_cyc_q[n0], t0 + RESP_OFS);
            check_eq("t6_rv0_dat", ls_rv_dat_q[n0], 32'hAA);
            check_eq("t6_rv1_cyc", ls_rv_cyc_q[n0 + 1], t0 + 2 * RESP_OFS);
            check_eq("t6_rv1_dat", ls_rv_dat_q[n0 + 1], 32'hBB);
        end

        // Random mixed traffic against the reference model
        for (int i = 0; i < 1500; i++) cycle_drive(1, 1);
        settle(60, done);
        check_eq("t7_settle", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
